alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
- Parametrised, registered successor to the team's 8-bit combinational ALU. Same 3-bit opcode map, generalised to WIDTH-bit operands with a 2*WIDTH result.
- Adds a valid/ready handshake on input and output, an iterative shift-add multiplier, saturating shifts, and carry/borrow and zero flags.
- Sits between an operand issue stage and a writeback stage that may apply backpressure.

Parameters:
- WIDTH, 8, operand width in bits; legal range is 2 or more. Result width is 2*WIDTH.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset; synchronous, active-high
- in_valid  in  1  operand/opcode presented
- in_ready  out  1  block can accept an operation
- a  in  WIDTH  operand A, unsigned
- b  in  WIDTH  operand B, unsigned; also the shift amount
- opcode  in  3  000 add, 001 sub, 010 mul, 011 shl, 100 shr, 101 and, 110 or, 111 xor
- out_valid  out  1  result and flags valid
- out_ready  in  1  consumer accepts the result
- result  out  2*WIDTH  registered result
- cout  out  1  add: carry out; sub: borrow (a<b); 0 for all other ops
- zero  out  1  1 when result == 0
- busy  out  1  high in the MUL state

Behaviour:
- Reset: one clock is a sync, active-high reset. rst high at a posedge forces:
  - state to IDLE
  - out_valid=0, result=0, cout=0, zero=0, busy=0
  - internal multiplier registers to 0
- rst overrides all other inputs in the same cycle.
- FSM states: IDLE, MUL, HOLD.
  - in_ready = (state==IDLE), driven combinationally from state.
  - busy = (state==MUL).
  - out_valid = (state==HOLD).
- Accept: an operation is accepted on a posedge with in_valid && in_ready. a, b and opcode are captured at that edge; later input changes have no effect.
- IDLE, non-mul opcode accepted:
  - result, cout and zero are computed and registered on the accept edge; state goes to HOLD.
  - out_valid is high the cycle after acceptance (1-clock latency).
- IDLE, mul accepted:
  - Latch a into the multiplicand register (zero-extended to 2*WIDTH) and b into the multiplier register.
  - Clear the accumulator and load an iteration counter with WIDTH. State goes to MUL.
- MUL, each clock:
  - If the multiplier LSB is 1, add the multiplicand to the accumulator.
  - Shift the multiplicand left by 1 and the multiplier right by 1; decrement the counter.
  - After the WIDTH-th iteration, register the accumulator into result, set zero, set cout=0, and go to HOLD.
  - out_valid is high WIDTH+1 clocks after the accept edge.
- HOLD:
  - result and flags are held stable. in_valid is ignored; in_ready=0.
  - On out_ready=1 at a posedge: go to IDLE, and out_valid drops next cycle.
  - No back-to-back accept: minimum 2 clocks per non-mul operation.
- Arithmetic, all unsigned, zero-extended to 2*WIDTH:
  - add: result = a+b; cout = result[WIDTH]; bits above WIDTH are 0.
  - sub: result = {WIDTH'b0,a} - {WIDTH'b0,b}, mod 2^(2*WIDTH), so a<b gives upper bits all 1; cout = (a<b).
  - mul: result = a*b, exact; it cannot overflow 2*WIDTH.
  - shl/shr: a is zero-extended, then shifted by the full value of b. If b >= 2*WIDTH, result = 0 (no modulo wrap). For shr, b >= WIDTH gives 0.
  - and/or/xor: bitwise on WIDTH bits; upper WIDTH bits are 0.
- zero is evaluated on the final 2*WIDTH result for every opcode.
- Reset mid-MUL or mid-HOLD aborts the operation: the result is discarded, out_valid is never raised for it, and in_ready=1 the cycle after reset deasserts.
- No state is left that depends on the aborted operation.

Optional Feature:
- Macro: ALU_SEQ_FAST_MUL_EN.
- Defined: mul is computed combinationally (a*b) and registered on the accept edge like every other opcode. The MUL state is never entered, busy is tied to 0, and all opcodes have 1-clock latency.
- Undefined: iterative multiply as above, WIDTH+1 clock latency, with no WIDTH x WIDTH multiplier array inferred.

Test Plan (WIDTH=8):
1. add a=0xFF, b=0x01 -> out_valid 1 clock after accept; result=0x0100, cout=1, zero=0. Then sub a=0x05, b=0x07 -> result=0xFFFE, cout=1.
2. mul a=0xFF, b=0xFF -> busy=1 and in_ready=0 for 8 clocks; out_valid 9 clocks after accept; result=0xFE01, cout=0. Then mul a=0x00, b=0x37 -> result=0, zero=1.
3. shl a=0x81, b=4 -> 0x0810. shl a=0x81, b=20 -> 0x0000, zero=1. shr a=0x81, b=7 -> 0x0001. xor a=0xAA, b=0xAA -> 0, zero=1.
4. Backpressure: add result with out_ready=0 for 5 clocks while in_valid=1 with new operands -> result and flags stable, in_ready=0, no new accept. Raise out_ready -> out_valid drops next cycle, in_ready=1.
5. Reset mid-multiply: mul a=0x12, b=0x34, rst=1 on the 3rd MUL clock -> out_valid never asserts, all outputs 0, in_ready=1 after rst falls. A following and a=0xF0, b=0x3C -> 0x0030.
6. With ALU_SEQ_FAST_MUL_EN defined: mul a=0xFF, b=0xFF -> result=0xFE01 one clock after accept; busy stays 0.

Source files
------------

// File: rtl/alu_seq.sv
// Registered WIDTH-bit ALU with valid/ready handshakes and an iterative shift-add multiplier.
// Define ALU_SEQ_FAST_MUL_EN to compute mul combinationally with single-cycle latency.
module alu_seq #(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [2:0]         opcode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] result,
  output logic               cout,
  output logic               zero,
  output logic               busy
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]      CNT_INIT = CW'(WIDTH);
  localparam logic [2*WIDTH-1:0] SH_LIM   = (2*WIDTH)'(2*WIDTH);

  typedef enum logic [1:0] {IDLE, MUL, HOLD} state_t;
  typedef enum logic [2:0] {
    OP_ADD = 3'b000, OP_SUB = 3'b001, OP_MUL = 3'b010, OP_SHL = 3'b011,
    OP_SHR = 3'b100, OP_AND = 3'b101, OP_OR  = 3'b110, OP_XOR = 3'b111
  } op_t;

  state_t               state_q, state_d;
  logic [2*WIDTH-1:0]   result_q, result_d;
  logic                 cout_q, cout_d;
  logic                 zero_q, zero_d;
  logic [2*WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [CW-1:0]        cnt_q, cnt_d;

  logic [2*WIDTH-1:0]   a_ext, b_ext, alu_res, acc_next;
  logic                 alu_cout, iter_mul;

  assign a_ext = {{WIDTH{1'b0}}, a};
  assign b_ext = {{WIDTH{1'b0}}, b};

  always_comb begin
    alu_res  = '0;
    alu_cout = 1'b0;
    case (op_t'(opcode))
      OP_ADD: begin
        alu_res  = a_ext + b_ext;
        alu_cout = alu_res[WIDTH];
      end
      OP_SUB: begin
        alu_res  = a_ext - b_ext;
        alu_cout = (a < b);
      end
`ifdef ALU_SEQ_FAST_MUL_EN
      OP_MUL: alu_res = a_ext * b_ext;
`else
      OP_MUL: alu_res = '0;
`endif
      OP_SHL: alu_res = (b_ext >= SH_LIM) ? '0 : (a_ext << b);
      OP_SHR: alu_res = (b_ext >= SH_LIM) ? '0 : (a_ext >> b);
      OP_AND: alu_res = {{WIDTH{1'b0}}, a & b};
      OP_OR:  alu_res = {{WIDTH{1'b0}}, a | b};
      OP_XOR: alu_res = {{WIDTH{1'b0}}, a ^ b};
      default: alu_res = '0;
    endcase
  end

`ifdef ALU_SEQ_FAST_MUL_EN
  assign iter_mul = 1'b0;
`else
  assign iter_mul = (op_t'(opcode) == OP_MUL);
`endif

  assign acc_next = acc_q + (mplier_q[0] ? mcand_q : '0);

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    cout_d   = cout_q;
    zero_d   = zero_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (iter_mul) begin
            mcand_d  = a_ext;
            mplier_d = b;
            acc_d    = '0;
            cnt_d    = CNT_INIT;
            state_d  = MUL;
          end else begin
            result_d = alu_res;
            cout_d   = alu_cout;
            zero_d   = (alu_res == '0);
            state_d  = HOLD;
          end
        end
      end
      MUL: begin
        acc_d    = acc_next;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q - CW'(1);
        // Last iteration: publish the sum that includes this cycle's partial product.
        if (cnt_q == CW'(1)) begin
          result_d = acc_next;
          zero_d   = (acc_next == '0);
          cout_d   = 1'b0;
          state_d  = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      result_q <= '0;
      cout_q   <= 1'b0;
      zero_q   <= 1'b0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      zero_q   <= zero_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == HOLD);
`ifdef ALU_SEQ_FAST_MUL_EN
  assign busy      = 1'b0;
`else
  assign busy      = (state_q == MUL);
`endif
  assign result    = result_q;
  assign cout      = cout_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_alu_seq.sv
// Randomised self-checking bench for alu_seq (WIDTH=8) against an arithmetic reference model.
module tb_alu_seq;

  localparam int unsigned W = 8;
  localparam longint MASK2 = (64'd1 << (2*W)) - 1;
`ifdef ALU_SEQ_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = W + 1;
`endif

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [W-1:0]   a = '0, b = '0;
  logic [2:0]     opcode = '0;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [2*W-1:0] result;
  logic           cout, zero, busy;

  int n_checks = 0;
  int n_errors = 0;

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .opcode(opcode), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .cout(cout), .zero(zero), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: plain unsigned arithmetic on the zero-extended operands.
  function automatic longint model_res(input int op, input longint x, input longint y);
    case (op)
      0: return (x + y) & MASK2;
      1: return (x - y) & MASK2;
      2: return (x * y) & MASK2;
      3: return (y >= 2*W) ? 0 : ((x << y) & MASK2);
      4: return (y >= 2*W) ? 0 : (x >> y);
      5: return x & y;
      6: return x | y;
      default: return x ^ y;
    endcase
  endfunction

  function automatic logic model_cout(input int op, input longint x, input longint y);
    if (op == 0) return (x + y) >= (64'd1 << W);
    if (op == 1) return x < y;
    return 1'b0;
  endfunction

  task automatic run_op(input int op, input int x, input int y, input int stall);
    longint er;
    logic   ec;
    int     lat;
    int     budget;
    int     exp_lat;
    er = model_res(op, x, y);
    ec = model_cout(op, x, y);
    exp_lat = (op == 2) ? MUL_LAT : 1;
    @(negedge clk);
    budget = 0;
    while (!in_ready && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    check("in_ready_before_accept", in_ready, 1'b1);
    in_valid = 1'b1;
    opcode   = 3'(op);
    a        = W'(x);
    b        = W'(y);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    a        = W'($urandom);
    b        = W'($urandom);
    opcode   = 3'($urandom);
    lat = 1;
    while (!out_valid && lat < 40) begin
      check("busy_in_mul", busy, 1'b1);
      check("in_ready_in_mul", in_ready, 1'b0);
      @(negedge clk);
      lat++;
    end
    check("latency", lat, exp_lat);
    check("result", result, er);
    check("cout", cout, ec);
    check("zero", zero, er == 0);
    check("busy_in_hold", busy, 1'b0);
    for (int k = 0; k < stall; k++) begin
      in_valid = 1'b1;
      opcode   = 3'($urandom);
      a        = W'($urandom);
      b        = W'($urandom);
      @(negedge clk);
      check("stall_out_valid", out_valid, 1'b1);
      check("stall_in_ready", in_ready, 1'b0);
      check("stall_result", result, er);
      check("stall_cout", cout, ec);
      check("stall_zero", zero, er == 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("release_out_valid", out_valid, 1'b0);
    check("release_in_ready", in_ready, 1'b1);
  endtask

  initial begin
    int op, x, y;
    repeat (3) @(negedge clk);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_result", result, 0);
    check("rst_cout", cout, 1'b0);
    check("rst_zero", zero, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    rst = 1'b0;

    run_op(0, 8'hFF, 8'h01, 0);
    run_op(1, 8'h05, 8'h07, 0);
    run_op(2, 8'hFF, 8'hFF, 0);
    run_op(2, 8'h00, 8'h37, 0);
    run_op(3, 8'h81, 4, 0);
    run_op(3, 8'h81, 20, 0);
    run_op(3, 8'h81, 16, 0);
    run_op(3, 8'h81, 15, 0);
    run_op(4, 8'h81, 7, 0);
    run_op(4, 8'h81, 8, 0);
    run_op(7, 8'hAA, 8'hAA, 0);
    run_op(0, 8'h12, 8'h34, 5);

    // Abort a multiply on its third MUL cycle.
    @(negedge clk);
    in_valid = 1'b1; opcode = 3'd2; a = 8'h12; b = 8'h34;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_out_valid", out_valid, 1'b0);
    check("abort_result", result, 0);
    check("abort_cout", cout, 1'b0);
    check("abort_zero", zero, 1'b0);
    check("abort_busy", busy, 1'b0);
    check("abort_in_ready", in_ready, 1'b1);
    for (int k = 0; k < W + 3; k++) begin
      @(negedge clk);
      check("abort_no_valid", out_valid, 1'b0);
    end
    run_op(5, 8'hF0, 8'h3C, 0);

    for (int n = 0; n < 80; n++) begin
      op = int'($urandom_range(0, 7));
      x  = int'($urandom_range(0, 255));
      y  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 20)) : int'($urandom_range(0, 255));
      if ($urandom_range(0, 7) == 0) x = 0;
      run_op(op, x, y, int'($urandom_range(0, 3)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
